// File: rtl/led_breathe_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_breathe_pwm_if
//  Description : Board-side signal bundle for the breathing LED stage.
//                The run enable goes into the stage. The five LED pin drives
//                come out of it.
//  Signals     : EN          run enable (high = run, low = pause)
//                RLED1..4    red LED drives
//                GLED5       green LED drive (lit while holding at full level)
//  Modports    : master - board/controller side (drives EN, observes LEDs)
//                slave  - LED stage side (observes EN, drives LEDs)
//  Revision    : 1.0  initial release
// ============================================================================
interface led_breathe_pwm_if;
    logic EN;
    logic RLED1;
    logic RLED2;
    logic RLED3;
    logic RLED4;
    logic GLED5;

    modport master (
        output EN,
        input  RLED1, RLED2, RLED3, RLED4, GLED5
    );

    modport slave (
        input  EN,
        output RLED1, RLED2, RLED3, RLED4, GLED5
    );
endinterface
`default_nettype wire

// File: rtl/led_breathe_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_breathe_pwm
//  Description : Breathing-brightness LED driver for the iCEstick. A step
//                prescaler clocks a four-state ramp FSM that produces a
//                triangular brightness level L. A free-running PWM counter
//                turns L into four LED duty cycles, plus a green HOLD_HI
//                indicator.
//  Parameters  : PWM_BITS   brightness/PWM resolution, MAX = 2**PWM_BITS-1
//                STEP_DIV   clocks per brightness step (>= 2)
//                HOLD_STEPS steps spent in each hold state (>= 1)
//  Ports       : CLK_IN     system clock, rising edge
//                RST        asynchronous active-high reset
//                led        slave modport: EN in; RLED1..4 and GLED5 out
//                           RLED1 duty L, RLED2 duty MAX-L,
//                           RLED3 duty L>>1, RLED4 duty (MAX-L)>>1
//  Revision    : 1.0  initial release
// ============================================================================
module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 47000,
    parameter int HOLD_STEPS = 64
) (
    input  wire logic         CLK_IN,
    input  wire logic         RST,
    led_breathe_pwm_if.slave  led
);

    localparam int c_DIV_W  = $clog2(STEP_DIV);
    localparam int c_HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] c_MAX       = '1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(STEP_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        S_RAMP_UP   = 2'd0,
        S_HOLD_HI   = 2'd1,
        S_RAMP_DOWN = 2'd2,
        S_HOLD_LO   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PWM_BITS-1:0]   r_level;
    logic [PWM_BITS-1:0]   w_level_nxt;
    logic [c_HOLD_W-1:0]   r_hold;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_DIV_W-1:0]    r_div;
    logic [PWM_BITS-1:0]   r_pwm;
    logic [PWM_BITS-1:0]   r_duty1;
    logic [PWM_BITS-1:0]   r_duty2;
    logic [PWM_BITS-1:0]   r_duty3;
    logic [PWM_BITS-1:0]   r_duty4;
    logic [3:0]            r_rled;
    logic                  r_gled;

    logic                  w_tick;
    logic [PWM_BITS-1:0]   w_inv_level;

    // One step per STEP_DIV enabled clocks; a paused clock never ticks, so
    // the prescaler phase survives a pause unchanged.
    assign w_tick      = led.EN && (r_div == c_DIV_LAST);
    assign w_inv_level = c_MAX - r_level;

    // ------------------------------------------------------------------
    // Ramp FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_state <= S_RAMP_UP;
            r_level <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Ramp FSM: next state. Everything moves on a tick only. L saturates
    // because each ramp leaves its state before stepping past 0 or MAX.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold;
        if (w_tick) begin
            case (r_state)
                S_RAMP_UP: begin
                    if (r_level == c_MAX) begin
                        w_state_nxt = S_HOLD_HI;
                        w_hold_nxt  = '0;
                    end else begin
                        w_level_nxt = r_level + 1'b1;
                    end
                end
                S_HOLD_HI: begin
                    if (r_hold == c_HOLD_LAST) w_state_nxt = S_RAMP_DOWN;
                    else                       w_hold_nxt  = r_hold + 1'b1;
                end
                S_RAMP_DOWN: begin
                    if (r_level == '0) begin
                        w_state_nxt = S_HOLD_LO;
                        w_hold_nxt  = '0;
                    end else begin
                        w_level_nxt = r_level - 1'b1;
                    end
                end
                S_HOLD_LO: begin
                    if (r_hold == c_HOLD_LAST) w_state_nxt = S_RAMP_UP;
                    else                       w_hold_nxt  = r_hold + 1'b1;
                end
                default: w_state_nxt = S_RAMP_UP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, PWM counter, duty shadows and registered LED drives.
    // Shadows reload only at the last count of a period, from the pre-tick
    // level, so a level step inside a period never alters that period.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_div   <= '0;
            r_pwm   <= '0;
            r_duty1 <= '0;
            r_duty2 <= '0;
            r_duty3 <= '0;
            r_duty4 <= '0;
            r_rled  <= '0;
            r_gled  <= 1'b0;
        end else if (led.EN) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            r_pwm <= r_pwm + 1'b1;
            if (r_pwm == c_MAX) begin
                r_duty1 <= r_level;
                r_duty2 <= w_inv_level;
                r_duty3 <= r_level >> 1;
                r_duty4 <= w_inv_level >> 1;
            end
            r_rled[0] <= (r_pwm < r_duty1);
            r_rled[1] <= (r_pwm < r_duty2);
            r_rled[2] <= (r_pwm < r_duty3);
            r_rled[3] <= (r_pwm < r_duty4);
            r_gled    <= (r_state == S_HOLD_HI);
        end else begin
            r_rled <= '0;
            r_gled <= 1'b0;
        end
    end

    assign led.RLED1 = r_rled[0];
    assign led.RLED2 = r_rled[1];
    assign led.RLED3 = r_rled[2];
    assign led.RLED4 = r_rled[3];
    assign led.GLED5 = r_gled;

endmodule
`default_nettype wire

// File: tb/tb_led_breathe_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_breathe_pwm
//  Description : Self-checking bench for led_breathe_pwm with PWM_BITS=4,
//                STEP_DIV=4, HOLD_STEPS=2 (MAX=15, 16-clock PWM period,
//                144-clock breathing cycle). A cycle-level reference model
//                queues the expected LED vector for every clock. A table of
//                hand-derived checkpoints and a few directed sequences cover
//                hold entry/exit, the pause, async reset and duty shadowing.
//                Output vector order: {RLED1,RLED2,RLED3,RLED4,GLED5}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_breathe_pwm;

    localparam int PB  = 4;
    localparam int SD  = 4;
    localparam int HS  = 2;
    localparam int MAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_breathe_pwm_if bif();

    led_breathe_pwm #(
        .PWM_BITS   (PB),
        .STEP_DIV   (SD),
        .HOLD_STEPS (HS)
    ) dut (
        .CLK_IN (clk),
        .RST    (rst),
        .led    (bif.slave)
    );

    // ------------------------------------------------------------------
    // Reference model state (0=RAMP_UP 1=HOLD_HI 2=RAMP_DOWN 3=HOLD_LO)
    // ------------------------------------------------------------------
    int m_state, m_L, m_pwm, m_div, m_hold;
    int m_d [4];

    logic [4:0] sb_q [$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    function automatic logic [4:0] dut_out();
        return {bif.RLED1, bif.RLED2, bif.RLED3, bif.RLED4, bif.GLED5};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_L = 0; m_pwm = 0; m_div = 0; m_hold = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        sb_q.delete();
    endtask

    // One rising edge of the model; the expected outputs after that edge are queued.
    task automatic model_edge(input logic en);
        logic [4:0] e;
        bit tick;
        e = '0;
        if (en) begin
            e = {m_pwm < m_d[0], m_pwm < m_d[1], m_pwm < m_d[2], m_pwm < m_d[3], m_state == 1};
            tick  = (m_div == SD - 1);
            m_div = tick ? 0 : m_div + 1;
            if (m_pwm == MAX) begin
                m_d[0] = m_L;
                m_d[1] = MAX - m_L;
                m_d[2] = m_L / 2;
                m_d[3] = (MAX - m_L) / 2;
            end
            m_pwm = (m_pwm + 1) % (MAX + 1);
            if (tick) begin
                case (m_state)
                    0: if (m_L == MAX) begin m_state = 1; m_hold = 0; end else m_L++;
                    1: if (m_hold == HS - 1) m_state = 2; else m_hold++;
                    2: if (m_L == 0) begin m_state = 3; m_hold = 0; end else m_L--;
                    default: if (m_hold == HS - 1) m_state = 0; else m_hold++;
                endcase
            end
        end
        sb_q.push_back(e);
    endtask

    // Apply EN for one clock, then compare the DUT against the queued model result.
    task automatic step(input logic en, input string tag);
        logic [4:0] e;
        bif.EN = en;
        @(posedge clk);
        #1;
        model_edge(en);
        cyc++;
        e = sb_q.pop_front();
        check(tag, dut_out(), e);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bif.EN = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", dut_out(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        int         cyc;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [12];
    int   hi_cnt;

    initial begin
        // Free-running checkpoints (cycle = edge count after reset release).
        tbl[0]  = '{1,   5'b00000};   // first clock after release: all dark
        tbl[1]  = '{10,  5'b00000};   // shadows still zero in the first period
        tbl[2]  = '{17,  5'b11110};   // duties 3/12/1/6 from L=3, pwm=0
        tbl[3]  = '{20,  5'b01010};   // pwm=3: RLED1 and RLED3 already off
        tbl[4]  = '{64,  5'b00000};   // pwm=15 and 16th tick into HOLD_HI
        tbl[5]  = '{65,  5'b10101};   // L=15 duties, GLED5 one clock later
        tbl[6]  = '{72,  5'b10001};   // last HOLD_HI tick, pwm=7 kills RLED3
        tbl[7]  = '{73,  5'b10000};   // RAMP_DOWN: GLED5 back to 0
        tbl[8]  = '{80,  5'b00000};   // pwm=15
        tbl[9]  = '{81,  5'b11100};   // pre-tick L=14 captured
        tbl[10] = '{82,  5'b10100};   // RLED2 duty 1 ends
        tbl[11] = '{145, 5'b01010};   // cycle repeats: back to L=0 duties

        rst    = 1'b1;
        bif.EN = 1'b0;
        #2;
        check("reset_async_state", dut_out(), 5'b00000);

        // --- Free run against the checkpoint table ---------------------
        do_reset();
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].cyc) step(1'b1, "free_run");
            check($sformatf("table_%0d", tbl[i].cyc), dut_out(), tbl[i].exp);
        end

        // --- Duty shadowing: period 17..32 sees L step 3->7 -------------
        do_reset();
        while (cyc < 16) step(1'b1, "shadow_pre");
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, "shadow_period");
            hi_cnt += int'(bif.RLED1);
        end
        check("shadow_hi_time", 5'(hi_cnt), 5'd3);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, "shadow_next");
            hi_cnt += int'(bif.RLED1);
        end
        check("next_hi_time", 5'(hi_cnt), 5'd7);

        // --- Async reset between edges at clk 90 ------------------------
        while (cyc < 90) step(1'b1, "pre_async");
        check("pre_async_out", dut_out(), 5'b10000);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", dut_out(), 5'b00000);
        do_reset();
        while (cyc < 17) step(1'b1, "post_rst");
        check("post_rst_17", dut_out(), 5'b11110);
        while (cyc < 20) step(1'b1, "post_rst");
        check("post_rst_20", dut_out(), 5'b01010);

        // --- Pause: EN low for 10 clocks after clk 30 -------------------
        do_reset();
        while (cyc < 30) step(1'b1, "pause_pre");
        for (int i = 0; i < 10; i++) step(1'b0, "pause");
        check("pause_dark", dut_out(), 5'b00000);
        while (cyc < 43) step(1'b1, "resume");
        check("resume_43", dut_out(), 5'b11110);
        while (cyc < 74) step(1'b1, "resume");
        check("gled_74_low", {4'b0000, bif.GLED5}, 5'b00000);
        step(1'b1, "resume");
        check("gled_75_high", {4'b0000, bif.GLED5}, 5'b00001);
        while (cyc < 83) step(1'b1, "resume");
        check("gled_83_low", {4'b0000, bif.GLED5}, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
